div_seq_ctrl: RTL and testbench
===============================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  dividend/divisor/mode offered.
REQ-004 in_ready  output  1  controller can accept an operation; high only in IDLE.
REQ-005 x  input  16  dividend, sampled on accept.
REQ-006 y  input  8  divisor, sampled on accept.
REQ-007 approx_en  input  1  approximation mode, sampled on accept; 0 = all exact rows, 1 = graded approximate rows.
REQ-008 out_valid  output  1  result available; held until out_ready.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 q  output  8  quotient.
REQ-011 r  output  8  remainder.
REQ-012 err  output  1  divide-by-zero or quotient overflow for the returned result.
REQ-013 busy  output  1  high in CALC or DONE.

Function
REQ-014 Accept SHALL occur on the edge where in_valid && in_ready; x, y and approx_en are latched, and in_valid is ignored at all other times.
REQ-015 The FSM SHALL have states IDLE, CALC and DONE: IDLE->CALC on a normal accept, IDLE->DONE on an error accept, CALC->DONE after iteration 7, DONE->IDLE on out_valid && out_ready.
REQ-016 A single shared 9-in/8-out restoring subtract row SHALL be reused once per CALC cycle.
REQ-017 A 3-bit iteration counter i SHALL be cleared on accept and run 0..7 in CALC.
REQ-018 Iteration 0 row input SHALL be x[15:7]. Iteration i>0 row input SHALL be {partial remainder[7:0], x[7-i]}.
REQ-019 Each iteration SHALL compute qs = ~borrow_out | in[8].
REQ-020 Each iteration SHALL set remainder = qs ? difference : in[7:0], and shift qs into q at the LSB (q MSB first).
REQ-021 Row approximation count k (number of low columns using approximate borrow/remainder cells) SHALL be 0 for all i when approx_en=0.
REQ-022 When approx_en=1, k SHALL be 0,0,1,2,3,4,5,6 for i=0..7.
REQ-023 Approximate cell equations: borrow = bin & (b | ~a); rem = a | (qs & (b ^ bin)). Exact cell equations: borrow = ~a&bin | ~a&b | b&bin; rem = qs ? a^b^bin : a. Row borrow-in = 0.
REQ-024 Latency: out_valid SHALL rise on the 9th edge after accept (8 CALC cycles + DONE entry). Error results SHALL rise on the 1st edge after accept.
REQ-025 Error: y==0 or x[15:8] >= y SHALL give err=1, q=8'hFF, r=8'h00, and no CALC cycles.
REQ-026 q, r and err SHALL be stable and out_valid held while in DONE without out_ready (backpressure, no overwrite).
REQ-027 in_ready SHALL be 0 in DONE, so there is no accept in the same cycle as result handoff. The minimum initiation interval is 10 cycles, 2 for error ops.
REQ-028 Input changes during CALC SHALL not affect the result.

Reset
REQ-029 rst SHALL force IDLE, i=0, q=0, r=0, err=0, out_valid=0, busy=0, in_ready=1 on the next edge.
REQ-030 rst mid-CALC or in DONE SHALL abort the operation with no result emitted.
REQ-031 rst SHALL take priority over a simultaneous accept or handoff.

Structure
REQ-032 Shared package div_pkg SHALL hold the state enum (IDLE/CALC/DONE), DIV_W=8, X_W=16, ITER_W=3, and the approx-count schedule table.
REQ-033 Sub-module div_row SHALL hold one 8-column row with a 3-bit k input selecting which low columns are approximate per column. It is combinational; all sequencing stays in div_seq_ctrl.

Verification
REQ-034 x=1000, y=10, approx_en=0 -> q=100, r=0, err=0, out_valid 9 cycles after accept.
REQ-035 x=65025, y=255, approx_en=0 -> q=255, r=0, err=0.
REQ-036 y=0 (any x) -> err=1, q=8'hFF, r=8'h00, out_valid 1 cycle after accept. Also x=16'h0A00, y=10 -> same error response.
REQ-037 approx_en=1 with random x, y (x[15:8]<y) -> q, r SHALL match a bit-accurate model of the fixed 8-row graded array (rows 0,0,1..6 approximate).
REQ-038 out_ready held low 5 cycles in DONE -> q, r and out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next edge.
REQ-039 rst asserted at CALC i=4 -> no out_valid. A new op accepted after reset completes correctly.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t   : controller states IDLE / CALC / DONE
//   DIV_W     : divisor / quotient / remainder width
//   X_W       : dividend width
//   ITER_W    : iteration counter width
//   APPROX_K  : per-iteration count of low approximate columns (approx mode)
//   row_k()   : approximate-column count for an iteration and mode
package div_pkg;

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned X_W    = 16;
  localparam int unsigned ITER_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Early rows carry the most significant quotient bits, so they stay exact;
  // later rows tolerate progressively more approximate low columns.
  localparam logic [ITER_W-1:0] APPROX_K [0:7] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6
  };

  function automatic logic [ITER_W-1:0] row_k(input logic [ITER_W-1:0] iter,
                                              input logic             en);
    return en ? APPROX_K[iter] : '0;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Handshake bus for div_seq_ctrl.
//   in_valid/in_ready + x, y, approx_en : operation offer
//   out_valid/out_ready + q, r, err     : result handoff
//   busy                                : operation in flight
// slave modport is the divider side, master modport the requester/consumer.
interface div_seq_ctrl_if;
  import div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [X_W-1:0]   x;
  logic [DIV_W-1:0] y;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] q;
  logic [DIV_W-1:0] r;
  logic             err;
  logic             busy;

  modport slave (
    input  in_valid, x, y, approx_en, out_ready,
    output in_ready, out_valid, q, r, err, busy
  );

  modport master (
    output in_valid, x, y, approx_en, out_ready,
    input  in_ready, out_valid, q, r, err, busy
  );

endinterface

// File: rtl/div_row.sv
// One combinational restoring-subtract row: in (9 bits) minus divisor b.
//   a   : row input, a[8] is the bit shifted out of the partial remainder
//   b   : divisor
//   k   : number of low columns built from approximate cells
//   qs  : quotient bit for this row
//   rem : next partial remainder (difference if qs, else a[7:0])
module div_row
  import div_pkg::*;
(
  input  logic [DIV_W:0]    a,
  input  logic [DIV_W-1:0]  b,
  input  logic [ITER_W-1:0] k,
  output logic              qs,
  output logic [DIV_W-1:0]  rem
);

  logic [DIV_W:0] bw;

  always_comb begin
    bw = '0;
    for (int unsigned j = 0; j < DIV_W; j++) begin
      if (j < 32'(k))
        bw[j+1] = bw[j] & (b[j] | ~a[j]);
      else
        bw[j+1] = (~a[j] & bw[j]) | (~a[j] & b[j]) | (b[j] & bw[j]);
    end
  end

  // A set a[8] means the shifted remainder already exceeds any 8-bit divisor.
  assign qs = ~bw[DIV_W] | a[DIV_W];

  // Approximate cells fold the restore mux into their own equation.
  always_comb begin
    rem = '0;
    for (int unsigned j = 0; j < DIV_W; j++) begin
      if (j < 32'(k))
        rem[j] = a[j] | (qs & (b[j] ^ bw[j]));
      else
        rem[j] = qs ? (a[j] ^ b[j] ^ bw[j]) : a[j];
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential 16/8 restoring divider controller, one shared row reused for
// 8 iterations, with optional graded approximate rows.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_seq_ctrl_if.slave (operation in, result out, busy)
// Divide-by-zero and quotient overflow skip CALC and return q=FF, r=00.
module div_seq_ctrl
  import div_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  div_seq_ctrl_if.slave  bus
);

  state_t            state;
  logic [ITER_W-1:0] i;
  logic [X_W-1:0]    xr;
  logic [DIV_W-1:0]  yr;
  logic              apx;
  logic [DIV_W-1:0]  q_q;
  logic [DIV_W-1:0]  rem_q;
  logic              err_q;
  logic              ov_q;
  logic              in_ready_q;
  logic              busy_q;

  logic [DIV_W:0]    row_a;
  logic [ITER_W-1:0] row_kv;
  logic              row_qs;
  logic [DIV_W-1:0]  row_rem;
  logic              bad_op;

  always_comb begin
    row_a = '0;
    if (i == '0)
      row_a = xr[X_W-1:DIV_W-1];
    else
      row_a = {rem_q, xr[{1'b0, 3'd7 - i}]};
  end

  assign row_kv = row_k(i, apx);
  assign bad_op = (bus.y == '0) || (bus.x[X_W-1:DIV_W] >= bus.y);

  div_row u_row (
    .a   (row_a),
    .b   (yr),
    .k   (row_kv),
    .qs  (row_qs),
    .rem (row_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      i          <= '0;
      xr         <= '0;
      yr         <= '0;
      apx        <= 1'b0;
      q_q        <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      ov_q       <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            xr         <= bus.x;
            yr         <= bus.y;
            apx        <= bus.approx_en;
            i          <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bad_op) begin
              q_q   <= '1;
              rem_q <= '0;
              err_q <= 1'b1;
              ov_q  <= 1'b1;
              state <= DONE;
            end else begin
              q_q   <= '0;
              rem_q <= '0;
              err_q <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_q   <= {q_q[DIV_W-2:0], row_qs};
          rem_q <= row_rem;
          i     <= i + 1'b1;
          if (i == '1) begin
            ov_q  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_q       <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          ov_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = ov_q;
  assign bus.q         = q_q;
  assign bus.r         = rem_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact mode is plain integer division; approx mode walks the
  // fixed 8-row array cell by cell, row t having max(t-1,0) approximate columns.
  function automatic void model(input logic [15:0] xv, input logic [7:0] yv, input bit en,
                                output logic [7:0] qo, output logic [7:0] ro, output bit eo);
    bit [8:0] a9;
    bit [7:0] rem;
    bit [8:0] bw;
    bit       qs;
    int       k;
    qo = 8'h00; ro = 8'h00; eo = 1'b0;
    if (yv == 8'd0 || int'(xv[15:8]) >= int'(yv)) begin
      qo = 8'hFF; ro = 8'h00; eo = 1'b1;
      return;
    end
    if (!en) begin
      qo = 8'(int'(xv) / int'(yv));
      ro = 8'(int'(xv) % int'(yv));
      return;
    end
    rem = 8'h00;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) a9 = xv[15:7];
      else        a9 = {rem, xv[4'(7 - t)]};
      k  = (t < 2) ? 0 : t - 1;
      bw = 9'd0;
      for (int c = 0; c < 8; c++) begin
        if (c < k) bw[c+1] = bw[c] & (yv[c] | ~a9[c]);
        else       bw[c+1] = (~a9[c] & bw[c]) | (~a9[c] & yv[c]) | (yv[c] & bw[c]);
      end
      qs = ~bw[8] | a9[8];
      for (int c = 0; c < 8; c++) begin
        if (c < k) rem[c] = a9[c] | (qs & (yv[c] ^ bw[c]));
        else       rem[c] = qs ? (a9[c] ^ yv[c] ^ bw[c]) : a9[c];
      end
      qo = {qo[6:0], qs};
    end
    ro = rem;
  endfunction

  task automatic run_op(input logic [15:0] xi, input logic [7:0] yi, input bit en,
                        input int stall, input bit scramble);
    logic [7:0] eq, er;
    bit         ee;
    int         lat;
    logic [7:0] q0, r0;
    model(xi, yi, en, eq, er, ee);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.x = xi; bus.y = yi; bus.approx_en = en; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.x = 16'($urandom); bus.y = 8'($urandom); bus.approx_en = 1'($urandom);
    end
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), ee ? 32'd1 : 32'd9);
    chk("q", 32'(bus.q), 32'(eq));
    chk("r", 32'(bus.r), 32'(er));
    chk("err", 32'(bus.err), 32'(ee));
    chk("busy_done", 32'(bus.busy), 32'd1);
    q0 = bus.q; r0 = bus.r;
    if (stall > 0) begin
      bus.in_valid = 1'b1;
      repeat (stall) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("hold_q", 32'(bus.q), 32'(q0));
      chk("hold_r", 32'(bus.r), 32'(r0));
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("handoff_valid", 32'(bus.out_valid), 32'd0);
    chk("handoff_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int        seen;
    logic [7:0] yv;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.approx_en = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_r", 32'(bus.r), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(16'd1000, 8'd10, 1'b0, 0, 1'b1);
    run_op(16'd65025, 8'd255, 1'b0, 0, 1'b0);
    run_op(16'h1234, 8'd0, 1'b0, 0, 1'b0);
    run_op(16'h0A00, 8'd10, 1'b1, 0, 1'b0);
    run_op(16'd777, 8'd13, 1'b0, 5, 1'b0);

    // Reset with the row at iteration 4: no result may appear.
    @(negedge clk);
    bus.x = 16'd5000; bus.y = 8'd77; bus.approx_en = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_q", 32'(bus.q), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op(16'd5000, 8'd77, 1'b0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      yv = 8'($urandom_range(1, 255));
      run_op({8'($urandom_range(0, int'(yv) - 1)), 8'($urandom)}, yv, 1'b1, 0, 1'b1);
    end
    for (int n = 0; n < 10; n++) begin
      yv = 8'($urandom_range(1, 255));
      run_op({8'($urandom_range(0, int'(yv) - 1)), 8'($urandom)}, yv, 1'b0, n % 3, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
